// File: rtl/ioctl_sdram_loader.sv
// Packs the ioctl ROM byte stream into little-endian 32-bit words and writes them to SDRAM.
// Single assembly word plus one pending word; ioctl_wait back-pressures while a write is pending.
module ioctl_sdram_loader #(
   parameter logic [22:0] BASE_ADDR = 23'h000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   input  logic        ioctl_download,
   output logic        ioctl_wait,
   output logic [22:0] sdram_addr,
   output logic [31:0] sdram_data,
   output logic        sdram_we,
   output logic        sdram_req,
   input  logic        sdram_ack,
   output logic        done,
   output logic        overrun
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;
   localparam logic [1:0] FLUSH  = 2'd3;

   logic [1:0]  state;
   logic        download_q;
   logic [31:0] asm_data;
   logic [22:0] asm_addr;
   logic [3:0]  asm_lanes;
   logic [31:0] pend_data;
   logic [22:0] pend_addr;
   logic        pend_vld;
   logic        req_r;
   logic        done_r;
   logic        overrun_r;

   logic [22:0] byte_waddr;
   logic [1:0]  byte_lane;
   logic [31:0] lane_data;
   logic [31:0] lane_mask;
   logic [3:0]  lane_bit;
   logic [31:0] merged;
   logic        accept;
   logic        hit;

   // Unwritten lanes of asm_data are always zero, so moving it to pending needs no extra fill.
   always_comb begin
      byte_waddr = BASE_ADDR + {5'd0, ioctl_addr[19:2]};
      byte_lane  = ioctl_addr[1:0];
      lane_data  = {24'd0, ioctl_data} << {byte_lane, 3'b000};
      lane_mask  = 32'h0000_00FF << {byte_lane, 3'b000};
      lane_bit   = 4'b0001 << byte_lane;
      merged     = (asm_data & ~lane_mask) | lane_data;
      accept     = ioctl_wr && !pend_vld && (state == ACTIVE);
      hit        = (asm_lanes != 4'b0000) && (byte_waddr == asm_addr);
   end

   assign ioctl_wait = pend_vld;
   assign sdram_addr = pend_addr;
   assign sdram_data = pend_data;
   assign sdram_req  = req_r;
   assign sdram_we   = req_r;
   assign done       = done_r;
   assign overrun    = overrun_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         download_q <= 1'b0;
         asm_data   <= 32'd0;
         asm_addr   <= 23'd0;
         asm_lanes  <= 4'b0000;
         pend_data  <= 32'd0;
         pend_addr  <= 23'd0;
         pend_vld   <= 1'b0;
         req_r      <= 1'b0;
         done_r     <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         download_q <= ioctl_download;
         done_r     <= 1'b0;
         if (ioctl_wr && pend_vld)
            overrun_r <= 1'b1;

         case (state)
            IDLE: begin
               if (ioctl_download && !download_q) begin
                  state     <= ACTIVE;
                  asm_data  <= 32'd0;
                  asm_addr  <= 23'd0;
                  asm_lanes <= 4'b0000;
                  pend_vld  <= 1'b0;
               end
            end

            ACTIVE: begin
               if (accept) begin
                  if (hit && asm_lanes[3]) begin
                     // Lane 3 landed last cycle and is due to move; fold this byte in as it goes.
                     pend_data <= merged;
                     pend_addr <= asm_addr;
                     pend_vld  <= 1'b1;
                     asm_data  <= 32'd0;
                     asm_lanes <= 4'b0000;
                  end else if (hit) begin
                     asm_data  <= merged;
                     asm_lanes <= asm_lanes | lane_bit;
                  end else begin
                     if (asm_lanes != 4'b0000) begin
                        pend_data <= asm_data;
                        pend_addr <= asm_addr;
                        pend_vld  <= 1'b1;
                     end
                     asm_data  <= lane_data;
                     asm_addr  <= byte_waddr;
                     asm_lanes <= lane_bit;
                  end
               end else if (asm_lanes[3] && !pend_vld) begin
                  pend_data <= asm_data;
                  pend_addr <= asm_addr;
                  pend_vld  <= 1'b1;
                  asm_data  <= 32'd0;
                  asm_lanes <= 4'b0000;
               end

               if (pend_vld) begin
                  state <= WRITE;
                  req_r <= 1'b1;
               end else if (!ioctl_download) begin
                  state <= FLUSH;
               end
            end

            WRITE: begin
               if (sdram_ack) begin
                  pend_vld <= 1'b0;
                  req_r    <= 1'b0;
                  state    <= ioctl_download ? ACTIVE : FLUSH;
               end
            end

            default: begin
               if (pend_vld) begin
                  state <= WRITE;
                  req_r <= 1'b1;
               end else if (asm_lanes != 4'b0000) begin
                  pend_data <= asm_data;
                  pend_addr <= asm_addr;
                  pend_vld  <= 1'b1;
                  asm_data  <= 32'd0;
                  asm_lanes <= 4'b0000;
               end else begin
                  done_r <= 1'b1;
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Scoreboard bench for ioctl_sdram_loader: two instances (base 0 and base 7FFFFF) share stimulus.
module tb_ioctl_sdram_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] ioctl_addr = 20'd0;
   logic [7:0]  ioctl_data = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        sdram_ack = 1'b0;

   logic        wait0, we0, req0, done0, ovr0;
   logic [22:0] addr0;
   logic [31:0] data0;
   logic        wait1, we1, req1, done1, ovr1;
   logic [22:0] addr1;
   logic [31:0] data1;

   ioctl_sdram_loader #(.BASE_ADDR(23'h000000)) dut0 (
      .clk(clk), .reset(reset), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
      .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download), .ioctl_wait(wait0),
      .sdram_addr(addr0), .sdram_data(data0), .sdram_we(we0), .sdram_req(req0),
      .sdram_ack(sdram_ack), .done(done0), .overrun(ovr0));

   ioctl_sdram_loader #(.BASE_ADDR(23'h7FFFFF)) dut1 (
      .clk(clk), .reset(reset), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
      .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download), .ioctl_wait(wait1),
      .sdram_addr(addr1), .sdram_data(data1), .sdram_we(we1), .sdram_req(req1),
      .sdram_ack(sdram_ack), .done(done1), .overrun(ovr1));

   always #5 clk = ~clk;

   typedef struct {
      logic [22:0] a0;
      logic [22:0] a1;
      logic [31:0] d;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   int   ack_en = 1;
   int   ack_delay = 3;
   int   ack_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [22:0] a0, input logic [22:0] a1, input logic [31:0] d);
      exp_t e;
      e.a0 = a0;
      e.a1 = a1;
      e.d  = d;
      sb.push_back(e);
   endtask

   // Monitor: every accepted write is popped and compared against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (req0 && sdram_ack) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write", addr0, data0);
         end else begin
            e = sb.pop_front();
            check("wr_addr_base0", 64'(addr0), 64'(e.a0));
            check("wr_data_base0", 64'(data0), 64'(e.d));
            check("wr_addr_base7fffff", 64'(addr1), 64'(e.a1));
            check("wr_data_base7fffff", 64'(data1), 64'(e.d));
            check("wr_we", 64'(we0), 64'd1);
            check("wr_req_base7fffff", 64'(req1), 64'd1);
         end
      end
      if (done0) done_cnt++;
      if (done0 !== done1) begin
         checks++;
         errors++;
         $display("FAIL done_mirror: got %0b, required %0b", done1, done0);
      end
   end

   // Memory-side responder: acks ack_delay cycles after req rises.
   always @(posedge clk) begin
      #1;
      if (sdram_ack) begin
         sdram_ack = 1'b0;
      end else if (req0 && ack_en != 0) begin
         ack_cnt++;
         if (ack_cnt >= ack_delay) begin
            sdram_ack = 1'b1;
            ack_cnt = 0;
         end
      end else begin
         ack_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [19:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic start_dl();
      ioctl_download = 1'b1;
      tick();
      tick();
   endtask

   task automatic wait_done(input int expected, input string name);
      for (int i = 0; i < 200; i++) begin
         if (done_cnt >= expected) break;
         tick();
      end
      tick();
      check(name, 64'(done_cnt), 64'(expected));
      check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      check("rst_req", 64'(req0), 64'd0);
      check("rst_we", 64'(we0), 64'd0);
      check("rst_done", 64'(done0), 64'd0);
      check("rst_overrun", 64'(ovr0), 64'd0);
      check("rst_wait", 64'(wait0), 64'd0);
      check("rst_addr", 64'(addr0), 64'd0);
      check("rst_data", 64'(data0), 64'd0);
      reset = 1'b0;
      tick();

      // Full word, ack after 3 cycles
      ack_en = 1;
      ack_delay = 3;
      push(23'h000000, 23'h7FFFFF, 32'h44332211);
      start_dl();
      send_byte(20'h0, 8'h11);
      send_byte(20'h1, 8'h22);
      send_byte(20'h2, 8'h33);
      send_byte(20'h3, 8'h44);
      repeat (12) tick();
      ioctl_download = 1'b0;
      wait_done(1, "full_word_done");

      // Single byte in lane 1 flushed on download fall
      push(23'h000001, 23'h000000, 32'h0000AA00);
      start_dl();
      send_byte(20'h5, 8'hAA);
      ioctl_download = 1'b0;
      wait_done(2, "partial_flush_done");

      // Address wrap on the 7FFFFF instance
      push(23'h000001, 23'h000000, 32'h0000003C);
      start_dl();
      send_byte(20'h4, 8'h3C);
      ioctl_download = 1'b0;
      wait_done(3, "wrap_done");

      // Address change pushes the partial word; new word stays in assembly
      push(23'h000000, 23'h7FFFFF, 32'h0000A55A);
      push(23'h000002, 23'h000001, 32'h00000077);
      start_dl();
      send_byte(20'h0, 8'h5A);
      send_byte(20'h1, 8'hA5);
      send_byte(20'h8, 8'h77);
      repeat (10) tick();
      check("asm_held_sb", 64'(sb.size()), 64'd1);
      ioctl_download = 1'b0;
      wait_done(4, "addr_change_done");

      // Long ack: back-pressure, dropped byte, overrun
      ack_delay = 20;
      push(23'h000000, 23'h7FFFFF, 32'h04030201);
      push(23'h000001, 23'h000000, 32'h08070605);
      start_dl();
      send_byte(20'h0, 8'h01);
      send_byte(20'h1, 8'h02);
      send_byte(20'h2, 8'h03);
      send_byte(20'h3, 8'h04);
      repeat (3) tick();
      check("wait_high", 64'(wait0), 64'd1);
      check("wait_high_base7fffff", 64'(wait1), 64'd1);
      send_byte(20'h9, 8'hEE);
      tick();
      check("overrun_set", 64'(ovr0), 64'd1);
      for (int i = 0; i < 60; i++) begin
         if (!wait0) break;
         tick();
      end
      check("wait_release", 64'(wait0), 64'd0);
      send_byte(20'h4, 8'h05);
      send_byte(20'h5, 8'h06);
      send_byte(20'h6, 8'h07);
      send_byte(20'h7, 8'h08);
      ioctl_download = 1'b0;
      wait_done(5, "backpressure_done");

      // Reset while a request is outstanding
      ack_en = 0;
      start_dl();
      send_byte(20'h0, 8'h01);
      send_byte(20'h1, 8'h02);
      send_byte(20'h2, 8'h03);
      send_byte(20'h3, 8'h04);
      for (int i = 0; i < 20; i++) begin
         if (req0) break;
         tick();
      end
      check("req_before_reset", 64'(req0), 64'd1);
      send_byte(20'h9, 8'hEE);
      reset = 1'b1;
      tick();
      check("reset_req", 64'(req0), 64'd0);
      check("reset_we", 64'(we0), 64'd0);
      check("reset_overrun", 64'(ovr0), 64'd0);
      check("reset_wait", 64'(wait0), 64'd0);
      reset = 1'b0;
      ioctl_download = 1'b0;
      repeat (10) tick();
      check("reset_no_done", 64'(done_cnt), 64'd5);
      check("reset_sb_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
